// File: rtl/data_memory.sv
// data_memory: 512 x 256-bit single-port line store answering each request after exactly MEM_LATENCY cycles.
// Optional macro DMEM_OOR_CHECK_EN: requests with addr_i[31:14] != 0 read back zeros and drop writes.
module data_memory #(
    parameter int unsigned MEM_LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o
);
    // state    | meaning
    // ST_IDLE  | accepting a request; enable_i sampled only here
    // ST_WAIT  | counting latency; access commits on the last WAIT cycle
    // ST_ACK   | ack_o high for this single cycle, then back to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MEM_LATENCY - 2);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [8:0]    idx_q, idx_d;
    logic [255:0]  wdata_q, wdata_d;
    logic          write_q, write_d;
    logic          oor_q, oor_d;
    logic          ack_q, ack_d;
    logic [255:0]  rdata_q, rdata_d;
    logic          commit;
    logic          mem_we;
    logic          unused_addr;

    logic [255:0]  mem [512];

`ifdef DMEM_OOR_CHECK_EN
    assign unused_addr = ^addr_i[4:0];
`else
    assign unused_addr = ^{addr_i[31:14], addr_i[4:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        oor_d   = oor_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[13:5];
                    wdata_d = data_i;
                    write_d = write_i;
                    cnt_d   = 8'd0;
`ifdef DMEM_OOR_CHECK_EN
                    oor_d   = |addr_i[31:14];
`else
                    oor_d   = 1'b0;
`endif
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // out-of-range reads return zeros; never flagged when the check is compiled out
        if (commit && !write_q) begin
            rdata_d = oor_q ? '0 : mem[idx_q];
        end
    end

    assign mem_we = commit && write_q && !oor_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 9'd0;
            wdata_q <= '0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // array contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter MEM_LATENCY, default 10: cycles from request acceptance to ack_o; legal range 2..255.
REQ-002 clk_i  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 addr_i  input  32  byte address of a 256-bit line; bits [4:0] ignored; line index = addr_i[13:5].
REQ-005 data_i  input  256  write line data.
REQ-006 enable_i  input  1  request valid; sampled only in IDLE.
REQ-007 write_i  input  1  1 = write line, 0 = read line; sampled with enable_i.
REQ-008 ack_o  output  1  one-cycle completion strobe.
REQ-009 data_o  output  256  registered read data.

Function
REQ-010 Storage: 512 lines x 256 bits (16 KB), single port; the array is not cleared by reset.
REQ-011 FSM states: IDLE, WAIT, ACK.
REQ-012 IDLE: enable_i=1 -> latch addr_i[13:5], data_i and write_i, load counter with 0, go to WAIT; enable_i=0 -> stay in IDLE.
REQ-013 WAIT: counter increments each cycle; at counter == MEM_LATENCY-2, commit the access and go to ACK.
REQ-014 Commit, write: the latched data is stored at the latched index; data_o is unchanged.
REQ-015 Commit, read: data_o is loaded with the line at the latched index.
REQ-016 ACK: ack_o=1 for exactly this one cycle, then unconditionally go to IDLE.
REQ-017 Latency: ack_o is high in cycle N+MEM_LATENCY, where N is the IDLE cycle that accepted the request.
REQ-018 data_o is valid in the ack_o cycle and is held until the next read commit.
REQ-019 During WAIT/ACK, changes on enable_i, write_i, addr_i and data_i are ignored, and a request dropped mid-transaction still completes and acks.
REQ-020 enable_i still high in the IDLE cycle after ACK is a new request, using the write_i/addr_i values present then; this supports the cache's write-back then refill sequence.
REQ-021 Back-to-back transactions have minimum spacing MEM_LATENCY+1 cycles (the IDLE cycle is mandatory).
REQ-022 Read after write to the same line returns the written data.
REQ-023 The counter is 8 bits and never wraps within a legal MEM_LATENCY.

Reset
REQ-024 rst_i=0 forces, asynchronously: state=IDLE, counter=0, ack_o=0, data_o=0, latched address/data/write=0.
REQ-025 Reset in WAIT aborts the transaction: no write is committed and no ack is issued.
REQ-026 A write committed before reset assertion is retained in the array.
REQ-027 After rst_i deasserts, the first request is accepted in IDLE with normal latency.

Configuration
REQ-028 Macro DMEM_OOR_CHECK_EN.
- Defined: addr_i[31:14] != 0 marks the request out-of-range. Such a read returns data_o = all zeros; such a write is dropped (array unchanged). Latency and ack are unchanged.
- Undefined: addr_i[31:14] is ignored and addresses alias modulo 16 KB.

Verification
REQ-029 Reset, then write 0xA5..A5 to addr 0x0000_0040 with MEM_LATENCY=10 -> ack_o high in exactly one cycle, 10 cycles after acceptance; read of 0x40 -> data_o=0xA5..A5 in its ack cycle.
REQ-030 Write-back then refill: write to 0x0000_0400 acked with enable_i held high and write_i dropped at ack, addr switched to 0x0000_0800 -> read accepted in the next IDLE cycle; second ack 11 cycles after the first.
REQ-031 enable_i deasserted 3 cycles into WAIT of a write to 0x20 -> ack still issued; a read of 0x20 returns the written data.
REQ-032 rst_i asserted 5 cycles into a write of 0xFF..FF to 0x60 (prior content 0x11..11) -> ack_o=0 and data_o=0 immediately; later read of 0x60 -> 0x11..11.
REQ-033 With DMEM_OOR_CHECK_EN: write 0xDEAD..BEEF to 0x0001_0000 then read 0x0001_0000 -> data_o=0, and line 0 is unchanged. Without the macro: the same read returns 0xDEAD..BEEF, and a read of 0x0000_0000 returns 0xDEAD..BEEF.
REQ-034 MEM_LATENCY=2: a read of a preloaded line -> ack_o 2 cycles after acceptance; continuous enable_i gives acks every 3 cycles.
